adrv9001_rx_framer: RTL
=======================

# adrv9001_rx_framer

Receive framer that sits directly downstream of the ADRV9001 receive channel, in the divided SSI clock domain. It accepts the channel's free-running 32-bit IQ sample stream (valid only, no backpressure) and buffers it in a FIFO. It re-emits the samples as a backpressured AXI-Stream with `tlast` every `frame_len` samples, for a DMA or packetizer. Samples that arrive while the buffer is full are dropped, flagged, and counted.

## Interface
- `ADDR_WIDTH`, 9: FIFO depth D = 2^ADDR_WIDTH entries of 32 bits.
- `clk`  in  1  sample clock; connect the receive channel's `m_axis_aclk`.
- `rstn`  in  1  reset, asynchronous assert, active-low; all state and outputs clear.
- `s_axis_tdata`  in  32  IQ sample {I[15:0], Q[15:0]}.
- `s_axis_tvalid`  in  1  sample valid; no ready, the source cannot stall.
- `capture_en`  in  1  level; a sample is accepted only when 1 in the same cycle as `s_axis_tvalid`.
- `frame_len`  in  16  samples per frame; 0 means 65536.
- `overflow_clr`  in  1  single-cycle pulse; clears `overflow`.
- `m_axis_tdata`  out  32  output sample, registered.
- `m_axis_tvalid`  out  1  output valid, registered.
- `m_axis_tlast`  out  1  last sample of the frame, registered.
- `m_axis_tready`  in  1  downstream ready.
- `fifo_level`  out  ADDR_WIDTH+1  FIFO occupancy 0..D; excludes the output register.
- `overflow`  out  1  sticky drop flag.
- `overflow_cnt`  out  16  dropped-sample count; saturates at 0xFFFF.

## Operation
- **Write**
  - A write request is `s_axis_tvalid & capture_en`.
  - If `fifo_level < D`, the sample is written.
  - If `fifo_level == D`, the sample is dropped. This holds even when a read frees an entry in the same cycle.
- **Drop**
  - On each dropped sample, `overflow` is set to 1.
  - On each dropped sample, `overflow_cnt` increments, stopping at 0xFFFF.
- **Overflow clear**
  - `overflow_clr` clears `overflow` only; `overflow_cnt` clears only on reset.
  - If `overflow_clr` and a drop occur in the same cycle, `overflow` = 1 (set wins).
- **Output register**
  - The output register loads from the FIFO head when it is empty, or when its current beat is transferring (`tvalid & tready`) and the FIFO is non-empty.
  - While `tvalid & !tready`, `tdata` and `tlast` are held stable and `tvalid` stays 1.
  - `tvalid` drops after a transfer only if the FIFO is empty.
- **Framing**
  - A beat counter `k` counts transferred beats: 0..L-1.
  - At `k == 0`, L is taken from the live `frame_len` and latched. All later beats of the frame use the latched value.
  - `tlast` = 1 on the beat where `k == L-1`. After that beat transfers, `k` returns to 0.
  - L = 1 sets `tlast` on every beat. L = 0 gives 65536-beat frames.
- **Frame boundaries**
  - Framing counts output beats, not input samples. Drops do not insert tlast and do not shorten the frame.
  - `capture_en` has no effect on framing. Buffered samples continue to drain after `capture_en` falls.
- **No backpressure upstream**
  - The block has no ready to the source, so it never stalls the receive channel.

## Timing
- **Reset values**
  - `m_axis_tvalid` = 0, `m_axis_tlast` = 0, `m_axis_tdata` = 0.
  - `fifo_level` = 0, `overflow` = 0, `overflow_cnt` = 0.
  - Beat counter `k` = 0 and the latched L = 1.
  - Reset mid-frame discards all buffered data. The first beat after reset starts a new frame.
- **Latency**
  - A sample written at cycle t into an empty FIFO with an empty output register appears with `m_axis_tvalid` = 1 at t+2: write at t, FIFO read at t+1, output register loaded at the t+2 edge.
- **Throughput**
  - Sustained rate is one beat per cycle while `tready` = 1.
- **Level**
  - `fifo_level` updates the cycle after a write or read.
  - It is unchanged on a cycle with both a write and a read.
- **Flags**
  - `overflow` and `overflow_cnt` update the cycle after the drop.

## Test plan
- **Basic framing:** frame_len = 4, `tready` = 1, 10 samples 0x00010001..0x000A000A with `capture_en` = 1 -> 10 beats in order, each 2 cycles after its input. `tlast` = 1 on beats 4 and 8, then beats 9 and 10 remain pending in an open frame.
- **Backpressure:** `tready` = 0 for 20 cycles during a stream -> `tdata` and `tlast` hold stable, `fifo_level` rises by 1 per sample. After `tready` returns, all samples appear in order with no duplication.
- **Overflow:** ADDR_WIDTH = 4 (D = 16), `tready` = 0, 20 samples -> `fifo_level` = 16, `overflow` = 1, `overflow_cnt` = 3. After `tready` = 1, exactly 17 beats (16 FIFO + 1 output register) are emitted. `overflow_clr` alone -> `overflow` = 0 and `overflow_cnt` = 3; `overflow_clr` in the same cycle as a drop -> `overflow` stays 1.
- **frame_len change mid-frame:** frame_len = 8, change to 3 after beat 2 -> `tlast` on beat 8, then on beats 11, 14, ...
- **capture_en gating:** `capture_en` = 0 with `s_axis_tvalid` = 1 -> no writes and `fifo_level` = 0. `capture_en` falls with 5 samples buffered -> all 5 still emitted.
- **Reset mid-frame:** assert `rstn` = 0 with 6 buffered samples -> all outputs go to 0 immediately, without waiting for `clk`. After release, new samples start a fresh frame with `k` = 0.

Source files
------------

// File: rtl/adrv9001_rx_framer.sv
// Receive framer for the ADRV9001 sample stream: buffers free-running IQ samples in a
// FIFO and re-emits them as a backpressured AXI-Stream with tlast every frame_len beats.
module adrv9001_rx_framer #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [31:0]           s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  capture_en,
  input  logic [15:0]           frame_len,
  input  logic                  overflow_clr,
  output logic [31:0]           m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [ADDR_WIDTH:0]   fifo_level,
  output logic                  overflow,
  output logic [15:0]           overflow_cnt
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_LEVEL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

  logic [31:0] mem_q [DEPTH];

  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0] level;

  logic [31:0] tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;

  logic [15:0] k_q, k_d;
  logic [15:0] len_q, len_d;

  logic        overflow_q, overflow_d;
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  logic        wr_req;
  logic        full;
  logic        empty;
  logic        wr_en;
  logic        drop;
  logic        load;
  logic [15:0] eff_len;
  logic        beat_last;

  // Pointers carry one extra wrap bit so that full and empty are distinguishable.
  assign level  = wr_ptr_q - rd_ptr_q;
  assign wr_req = s_axis_tvalid & capture_en;
  assign full   = (level == FULL_LEVEL);
  assign empty  = (level == '0);
  assign wr_en  = wr_req & ~full;
  assign drop   = wr_req & full;
  assign load   = ~empty & (~tvalid_q | m_axis_tready);

  // A new frame samples frame_len live; 0 wraps to 0xFFFF as last index, i.e. 65536 beats.
  assign eff_len   = (k_q == 16'd0) ? frame_len : len_q;
  assign beat_last = (k_q == (eff_len - 16'd1));

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= s_axis_tdata;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (load) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // The beat counter advances when a beat enters the output register; beats leave in order.
  always_comb begin
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    k_d      = k_q;
    len_d    = len_q;
    if (load) begin
      tdata_d  = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
      tvalid_d = 1'b1;
      tlast_d  = beat_last;
      k_d      = beat_last ? 16'd0 : (k_q + 16'd1);
      if (k_q == 16'd0) begin
        len_d = frame_len;
      end
    end else if (tvalid_q && m_axis_tready) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end
  end

  always_comb begin
    overflow_d = overflow_q;
    ovf_cnt_d  = ovf_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (ovf_cnt_q != 16'hFFFF) begin
        ovf_cnt_d = ovf_cnt_q + 16'd1;
      end
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      k_q        <= 16'd0;
      len_q      <= 16'd1;
      overflow_q <= 1'b0;
      ovf_cnt_q  <= 16'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      k_q        <= k_d;
      len_q      <= len_d;
      overflow_q <= overflow_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign fifo_level    = level;
  assign overflow      = overflow_q;
  assign overflow_cnt  = ovf_cnt_q;

endmodule
